// File: rtl/param_stack.sv
// param_stack: parametrised LIFO stack with occupancy status, simultaneous
// push+pop (replace-top / bypass) and one-cycle overflow/underflow pulses.
// Optional macro PARAM_STACK_PEEK_EN adds the combinational top/top_valid
// peek outputs.
module param_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
`ifdef PARAM_STACK_PEEK_EN
  ,
  output logic [DATA_W-1:0] top,
  output logic              top_valid
`endif
);

  // Index width only needs to cover 0..DEPTH-1; it is never allowed to wrap.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  count_reg, count_next;
  logic [DATA_W-1:0] data_out_reg, data_out_next;
  logic              data_valid_reg, data_valid_next;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;

  logic              full_w;
  logic              empty_w;
  logic [IDX_W-1:0]  top_idx;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;

  // Status decoded from the registered count so it reflects the last edge.
  always_comb begin
    full_w  = (count_reg == CNT_W'(DEPTH));
    empty_w = (count_reg == '0);
    // Forced to 0 when empty so the index always stays inside the array.
    top_idx = empty_w ? '0 : IDX_W'(count_reg - 1'b1);
  end

  // Per-edge decision: bypass, replace-top, push, pop, or reject.
  always_comb begin
    count_next      = count_reg;
    data_out_next   = data_out_reg;
    data_valid_next = 1'b0;
    overflow_next   = 1'b0;
    underflow_next  = 1'b0;
    wr_en           = 1'b0;
    wr_idx          = top_idx;
    case ({push, pop})
      2'b11: begin
        data_valid_next = 1'b1;
        if (empty_w) begin
          data_out_next = data_in;
        end else begin
          data_out_next = mem[top_idx];
          wr_en         = 1'b1;
          wr_idx        = top_idx;
        end
      end
      2'b10: begin
        if (full_w) begin
          overflow_next = 1'b1;
        end else begin
          wr_en      = 1'b1;
          wr_idx     = IDX_W'(count_reg);
          count_next = count_reg + 1'b1;
        end
      end
      2'b01: begin
        if (empty_w) begin
          underflow_next = 1'b1;
        end else begin
          data_out_next   = mem[top_idx];
          data_valid_next = 1'b1;
          count_next      = count_reg - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Control/status registers; reset wins over any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg      <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      count_reg      <= count_next;
      data_out_reg   <= data_out_next;
      data_valid_reg <= data_valid_next;
      overflow_reg   <= overflow_next;
      underflow_reg  <= underflow_next;
    end
  end

  // Storage entries: one write-enabled register per slot, never cleared.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture data_in when this slot is the selected write target.
      always_ff @(posedge clk) begin
        if (!reset && wr_en && (wr_idx == IDX_W'(gi))) begin
          mem[gi] <= data_in;
        end
      end
    end
  endgenerate

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign full       = full_w;
  assign empty      = empty_w;
  assign count      = count_reg;
  assign overflow   = overflow_reg;
  assign underflow  = underflow_reg;

`ifdef PARAM_STACK_PEEK_EN
  assign top       = empty_w ? '0 : mem[top_idx];
  assign top_valid = !empty_w;
`endif

endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: drives a DEPTH=4 and a DEPTH=5 stack with the same directed
// vectors, checks both every cycle against a stack model, and pins the model
// with hand-computed literal expectations.
module tb_param_stack;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] dout4, dout5;
  logic       dv4, dv5, full4, full5, empty4, empty5;
  logic       ovf4, ovf5, unf4, unf5;
  logic [2:0] cnt4, cnt5;
`ifdef PARAM_STACK_PEEK_EN
  logic [7:0] top4, top5;
  logic       tv4, tv5;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  param_stack #(.DATA_W(8), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .data_out(dout4), .data_valid(dv4), .full(full4), .empty(empty4),
    .count(cnt4), .overflow(ovf4), .underflow(unf4)
`ifdef PARAM_STACK_PEEK_EN
    , .top(top4), .top_valid(tv4)
`endif
  );

  param_stack #(.DATA_W(8), .DEPTH(5)) dut5 (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .data_out(dout5), .data_valid(dv5), .full(full5), .empty(empty5),
    .count(cnt5), .overflow(ovf5), .underflow(unf5)
`ifdef PARAM_STACK_PEEK_EN
    , .top(top5), .top_valid(tv5)
`endif
  );

  // ---------------- model: a plain LIFO per DUT ----------------
  int         mdepth [2] = '{4, 5};
  logic [7:0] mst    [2][$];
  logic [7:0] mdout  [2];
  bit         mdv    [2];
  bit         movf   [2];
  bit         munf   [2];
  bit         active = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mst[k].delete();
        mdout[k] = 8'h00;
        mdv[k]   = 1'b0;
        movf[k]  = 1'b0;
        munf[k]  = 1'b0;
      end else begin
        mdv[k]  = 1'b0;
        movf[k] = 1'b0;
        munf[k] = 1'b0;
        if (push && pop) begin
          mdv[k] = 1'b1;
          if (mst[k].size() == 0) begin
            mdout[k] = data_in;
          end else begin
            mdout[k] = mst[k].pop_back();
            mst[k].push_back(data_in);
          end
        end else if (push) begin
          if (mst[k].size() == mdepth[k]) movf[k] = 1'b1;
          else mst[k].push_back(data_in);
        end else if (pop) begin
          if (mst[k].size() == 0) begin
            munf[k] = 1'b1;
          end else begin
            mdout[k] = mst[k].pop_back();
            mdv[k]   = 1'b1;
          end
        end
      end
    end
    if (reset) active = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cmp_dut(input int k, input logic [7:0] d, input logic v,
                         input logic [2:0] c, input logic f, input logic e,
                         input logic o, input logic u);
    int sz;
    sz = mst[k].size();
    chk($sformatf("dut%0d.data_out", mdepth[k]), {24'h0, d}, {24'h0, mdout[k]});
    chk($sformatf("dut%0d.data_valid", mdepth[k]), {31'h0, v}, {31'h0, mdv[k]});
    chk($sformatf("dut%0d.count", mdepth[k]), {29'h0, c}, sz);
    chk($sformatf("dut%0d.full", mdepth[k]), {31'h0, f}, (sz == mdepth[k]) ? 1 : 0);
    chk($sformatf("dut%0d.empty", mdepth[k]), {31'h0, e}, (sz == 0) ? 1 : 0);
    chk($sformatf("dut%0d.overflow", mdepth[k]), {31'h0, o}, {31'h0, movf[k]});
    chk($sformatf("dut%0d.underflow", mdepth[k]), {31'h0, u}, {31'h0, munf[k]});
  endtask

`ifdef PARAM_STACK_PEEK_EN
  task automatic cmp_peek(input int k, input logic [7:0] t, input logic tv);
    int sz;
    logic [7:0] exp_top;
    sz = mst[k].size();
    exp_top = (sz == 0) ? 8'h00 : mst[k][sz-1];
    chk($sformatf("dut%0d.top", mdepth[k]), {24'h0, t}, {24'h0, exp_top});
    chk($sformatf("dut%0d.top_valid", mdepth[k]), {31'h0, tv}, (sz != 0) ? 1 : 0);
  endtask
`endif

  // Compare process: every cycle once reset has been seen.
  always @(negedge clk) begin
    if (active) begin
      cmp_dut(0, dout4, dv4, cnt4, full4, empty4, ovf4, unf4);
      cmp_dut(1, dout5, dv5, cnt5, full5, empty5, ovf5, unf5);
`ifdef PARAM_STACK_PEEK_EN
      cmp_peek(0, top4, tv4);
      cmp_peek(1, top5, tv5);
`endif
    end
  end

  // One transaction per clock; outputs are observed 1 time unit after the edge.
  task automatic step(input logic p, input logic q, input logic [7:0] d, input logic r);
    push = p; pop = q; data_in = d; reset = r;
    @(posedge clk);
    #1;
    $display("txn rst=%0d push=%0d pop=%0d din=%02h | d4: cnt=%0d dout=%02h dv=%0d ovf=%0d unf=%0d | d5: cnt=%0d dout=%02h dv=%0d",
             r, p, q, d, cnt4, dout4, dv4, ovf4, unf4, cnt5, dout5, dv5);
  endtask

  initial begin
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    chk("rst.count", {29'h0, cnt4}, 0);
    chk("rst.empty", {31'h0, empty4}, 1);
    chk("rst.data_out", {24'h0, dout4}, 0);

    step(1, 0, 8'h11, 0); chk("push1.count", {29'h0, cnt4}, 1);
    step(1, 0, 8'h22, 0); chk("push2.count", {29'h0, cnt4}, 2);
    step(1, 0, 8'h33, 0); chk("push3.count", {29'h0, cnt4}, 3);
    step(1, 0, 8'h44, 0); chk("push4.count", {29'h0, cnt4}, 4);
    chk("push4.full", {31'h0, full4}, 1);
    chk("push4.overflow", {31'h0, ovf4}, 0);

    step(1, 0, 8'h55, 0);
    chk("ovf.pulse", {31'h0, ovf4}, 1);
    chk("ovf.count", {29'h0, cnt4}, 4);
    chk("d5.full", {31'h0, full5}, 1);
    step(1, 0, 8'h66, 0);
    chk("d5.ovf", {31'h0, ovf5}, 1);
    step(0, 0, 8'h00, 0);
    chk("ovf.cleared", {31'h0, ovf4}, 0);

    step(0, 1, 8'h00, 0); chk("pop1.data", {24'h0, dout4}, 32'h44);
    chk("pop1.valid", {31'h0, dv4}, 1);
    step(0, 1, 8'h00, 0); chk("pop2.data", {24'h0, dout4}, 32'h33);
    step(0, 1, 8'h00, 0); chk("pop3.data", {24'h0, dout4}, 32'h22);
    step(0, 1, 8'h00, 0); chk("pop4.data", {24'h0, dout4}, 32'h11);
    chk("pop4.empty", {31'h0, empty4}, 1);
    chk("d5.pop4.data", {24'h0, dout5}, 32'h22);

    step(0, 1, 8'h00, 0);
    chk("unf.pulse", {31'h0, unf4}, 1);
    chk("unf.valid", {31'h0, dv4}, 0);
    chk("unf.hold", {24'h0, dout4}, 32'h11);
    step(0, 1, 8'h00, 0);
    chk("d5.unf", {31'h0, unf5}, 1);

    step(1, 0, 8'hA0, 0);
    step(1, 0, 8'hA1, 0);
    step(1, 1, 8'hB0, 0);
    chk("rep.data", {24'h0, dout4}, 32'hA1);
    chk("rep.valid", {31'h0, dv4}, 1);
    chk("rep.count", {29'h0, cnt4}, 2);
    step(0, 1, 8'h00, 0); chk("rep.pop", {24'h0, dout4}, 32'hB0);
    step(0, 1, 8'h00, 0); chk("rep.pop2", {24'h0, dout4}, 32'hA0);
    step(0, 0, 8'h00, 0);

    step(1, 1, 8'h7E, 0);
    chk("byp.data", {24'h0, dout4}, 32'h7E);
    chk("byp.valid", {31'h0, dv4}, 1);
    chk("byp.count", {29'h0, cnt4}, 0);
    chk("byp.flags", {30'h0, ovf4, unf4}, 0);

    step(1, 0, 8'h01, 0);
`ifdef PARAM_STACK_PEEK_EN
    chk("peek.top1", {24'h0, top4}, 32'h01);
`endif
    step(1, 0, 8'h02, 0);
`ifdef PARAM_STACK_PEEK_EN
    chk("peek.top2", {24'h0, top4}, 32'h02);
`endif
    step(1, 0, 8'h03, 1);
    chk("rstmid.count", {29'h0, cnt4}, 0);
    chk("rstmid.empty", {31'h0, empty4}, 1);
    chk("rstmid.data_out", {24'h0, dout4}, 0);
`ifdef PARAM_STACK_PEEK_EN
    chk("rstmid.top_valid", {31'h0, tv4}, 0);
`endif
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
